slt_sort_engine: RTL and testbench

- Multi-cycle sorter that loads DEPTH signed words and sorts them ascending with bubble sort, then streams them out.
- Each cycle it makes one comparison on a single shared `slt` instance (signed a < b), reusing the existing ALU comparator instead of a comparator network.
- It sits between a valid/ready producer and a valid/ready consumer.

---
 rtl/slt.sv | 12 +
 rtl/slt_sort_engine.sv | 135 +++++++++++++
 tb/tb_slt_sort_engine.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/slt.sv
// rtl/slt.sv - signed set-less-than comparator (out = a < b, two's complement)
module slt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out
);

    assign out = $signed(a) < $signed(b);

endmodule

// File: rtl/slt_sort_engine.sv
// rtl/slt_sort_engine.sv - load/bubble-sort/drain engine built around one shared slt comparator
module slt_sort_engine #(
    parameter int N     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] cmp_idx;
    logic [AW-1:0] idx_hi;
    logic [AW-1:0] pass_cnt;
    logic          swap_flag;
    logic          lt;
    logic          in_fire;
    logic          out_fire;
    logic          last_word;
    logic          last_out;
    logic          last_cmp;
    logic          last_pass;
    logic          sort_done;

    assign idx_hi    = cmp_idx + AW'(1);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign last_word = (wr_ptr == AW'(DEPTH - 1));
    assign last_out  = (rd_ptr == AW'(DEPTH - 1));
    assign last_cmp  = (cmp_idx == AW'(DEPTH - 2));
    assign last_pass = (pass_cnt == AW'(DEPTH - 1));
    // A pass ends clean only if neither earlier compares nor this final one swapped.
    assign sort_done = (state == SORT) && last_cmp && (!(swap_flag || lt) || last_pass);

    // The only ordering decision in the engine: is the upper neighbour strictly smaller?
    slt #(.N(N)) u_slt (
        .a   (mem[idx_hi]),
        .b   (mem[cmp_idx]),
        .out (lt)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fill, sort until a clean pass (or the pass cap), then drain
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_fire && last_word) state_nxt = SORT;
            SORT:    if (sort_done) state_nxt = DRAIN;
            DRAIN:   if (out_fire && last_out) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Outputs decoded from state; out_data is held at zero outside DRAIN
    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == DRAIN);
        busy      = (state == SORT);
        out_data  = '0;
        if (state == DRAIN) begin
            out_data = mem[rd_ptr];
        end
    end

    // Pointers and sort bookkeeping; everything returns to zero when a sort finishes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmp_idx   <= '0;
            pass_cnt  <= '0;
            swap_flag <= 1'b0;
        end else begin
            if (in_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (out_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (state == SORT) begin
                if (sort_done) begin
                    cmp_idx   <= '0;
                    pass_cnt  <= '0;
                    swap_flag <= 1'b0;
                end else if (last_cmp) begin
                    cmp_idx   <= '0;
                    pass_cnt  <= pass_cnt + AW'(1);
                    swap_flag <= 1'b0;
                end else begin
                    cmp_idx <= idx_hi;
                    if (lt) begin
                        swap_flag <= 1'b1;
                    end
                end
            end
        end
    end

    // Storage: written on load handshakes, neighbours exchanged on a strict less-than
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_ptr] <= in_data;
        end else if ((state == SORT) && lt) begin
            mem[cmp_idx] <= mem[idx_hi];
            mem[idx_hi]  <= mem[cmp_idx];
        end
    end

endmodule

// File: tb/tb_slt_sort_engine.sv
// tb/tb_slt_sort_engine.sv - scoreboard bench for slt_sort_engine
module tb_slt_sort_engine;

    localparam int N     = 32;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] out_data;
    logic         busy;

    int           n_pass = 0;
    int           n_total = 0;
    logic [31:0]  exp_q[$];
    int           ready_mode = 0;
    int           busy_cur = 0;
    int           busy_last = 0;
    logic [31:0]  held_data = '0;
    bit           held = 1'b0;

    slt_sort_engine #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endfunction

    // Monitor: pops expected words on output handshakes, checks hold stability, measures busy length
    always @(negedge clk) begin
        if (!rst) begin
            busy_cur = 0;
            held     = 1'b0;
        end else begin
            if (busy) busy_cur++;
            else if (busy_cur > 0) begin
                busy_last = busy_cur;
                busy_cur  = 0;
            end
            if (out_valid && held) check("out_stable", out_data, held_data);
            held = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_output", 32'd1, 32'd0);
                else check("out_data", out_data, exp_q.pop_front());
            end else if (out_valid) begin
                held      = 1'b1;
                held_data = out_data;
            end
        end
    end

    // Consumer ready: always ready or randomly stalling
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input bit gap);
        int  t;
        bit  hs;
        t  = 0;
        hs = 1'b0;
        if (gap) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        while (!hs && t < 3000) begin
            @(negedge clk);
            hs = in_ready;
            tick();
            t++;
        end
        if (!hs) check("in_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_batch(input logic [31:0] v[DEPTH], input bit gap);
        for (int i = 0; i < DEPTH; i++) send_word(v[i], gap);
    endtask

    task automatic push_exp(input logic [31:0] e[DEPTH]);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(e[i]);
    endtask

    task automatic push_sorted(input logic [31:0] v[DEPTH]);
        logic [31:0] s[DEPTH];
        logic [31:0] k;
        int          j;
        s = v;
        for (int i = 1; i < DEPTH; i++) begin
            k = s[i];
            j = i - 1;
            while (j >= 0 && $signed(s[j]) > $signed(k)) begin
                s[j+1] = s[j];
                j--;
            end
            s[j+1] = k;
        end
        push_exp(s);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && in_ready) && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] v[DEPTH];
        logic [31:0] e[DEPTH];

        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        rst = 1'b1;
        tick();

        // Already sorted
        v = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        push_exp(v);
        busy_last = 0;
        send_batch(v, 1'b0);
        wait_idle();
        check("busy_sorted", busy_last, 32'd7);

        // Reverse sorted, with ignored in_valid traffic during SORT
        v = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        e = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        push_exp(e);
        busy_last = 0;
        send_batch(v, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h63;
        repeat (20) tick();
        in_valid = 1'b0;
        wait_idle();
        check("busy_reverse", busy_last, 32'd56);

        // Signed extremes
        v = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h80000001, 32'h5, 32'hFFFFFFFB};
        e = '{32'h80000000, 32'h80000001, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h5, 32'h7FFFFFFF};
        push_exp(e);
        send_batch(v, 1'b0);
        wait_idle();

        // Duplicates with a stalling consumer
        ready_mode = 1;
        v = '{32'd3, 32'd3, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd3};
        e = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd3, 32'd3, 32'd3, 32'd3};
        push_exp(e);
        send_batch(v, 1'b0);
        wait_idle();

        // Reset in the middle of a sort
        ready_mode = 0;
        v = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        send_batch(v, 1'b0);
        repeat (10) tick();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_data", out_data, 32'd0);
        tick();
        rst = 1'b1;
        v = '{32'd10, 32'hFFFFFFF0, 32'd4, 32'd4, 32'd0, 32'h80000000, 32'd2, 32'd1};
        e = '{32'h80000000, 32'hFFFFFFF0, 32'd0, 32'd1, 32'd2, 32'd4, 32'd4, 32'd10};
        push_exp(e);
        send_batch(v, 1'b0);
        wait_idle();

        // Random batches with producer gaps and consumer stalls
        ready_mode = 1;
        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < DEPTH; i++) v[i] = $unsigned($random);
            push_sorted(v);
            send_batch(v, 1'b1);
            wait_idle();
        end
        ready_mode = 0;
        repeat (5) tick();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
